// File: rtl/banner_pkg.sv
// Shared types and nibble-rotation helpers for the banner scroll controller.
package banner_pkg;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DIGIT_W   = 4;
  localparam int MSG_MAX_W = 256;
  localparam int IDX_W     = $clog2(MSG_MAX_W);

  // Rotate the low w bits of d right by one digit: {d[3:0], d[w-1:4]}.
  function automatic logic [MSG_MAX_W-1:0] rotate_r(input logic [MSG_MAX_W-1:0] d,
                                                    input int w);
    logic [MSG_MAX_W-1:0] r;
    logic [IDX_W-1:0]     src;
    logic [IDX_W-1:0]     dst;
    r = '0;
    for (int i = 0; i < MSG_MAX_W; i++) begin
      dst = IDX_W'(i);
      src = IDX_W'((i + DIGIT_W) % w);
      if (i < w) r[dst] = d[src];
    end
    return r;
  endfunction

  // Rotate the low w bits of d left by one digit: {d[w-5:0], d[w-1:w-4]}.
  function automatic logic [MSG_MAX_W-1:0] rotate_l(input logic [MSG_MAX_W-1:0] d,
                                                    input int w);
    logic [MSG_MAX_W-1:0] r;
    logic [IDX_W-1:0]     src;
    logic [IDX_W-1:0]     dst;
    r = '0;
    for (int i = 0; i < MSG_MAX_W; i++) begin
      dst = IDX_W'(i);
      src = IDX_W'((i + w - DIGIT_W) % w);
      if (i < w) r[dst] = d[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/banner_step_timer.sv
// Step-cycle detector: flags the cycle in which the running count reaches the period.
module banner_step_timer #(
  parameter int CNT_W = 27
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic             clear,
  output logic             step
);

  logic [CNT_W-1:0] last_cnt;

  // A period of zero behaves as one; >= lets a shortened period fire at once.
  always_comb begin
    last_cnt = (period == '0) ? '0 : period - CNT_W'(1);
    step     = enable & ~clear & (cnt >= last_cnt);
  end

endmodule

// File: rtl/banner_scroll_controller.sv
// Rotating seven-segment message sequencer with run/pause, direction and message load.
// Optional ping-pong scrolling when BANNER_BOUNCE_EN is defined.
module banner_scroll_controller
  import banner_pkg::*;
#(
  parameter int                        DIGITS     = 10,
  parameter int                        WIN_DIGITS = 4,
  parameter int                        CNT_W      = 27,
  parameter logic [DIGIT_W*DIGITS-1:0] RESET_MSG  = 40'h0123456789
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            run_i,
  input  logic                            dir_i,
  input  logic [CNT_W-1:0]                step_period_i,
  input  logic                            load_valid_i,
  input  logic [DIGIT_W*DIGITS-1:0]       load_data_i,
  output logic                            load_ready_o,
  output logic [DIGIT_W*WIN_DIGITS-1:0]   win_o,
  output logic                            step_o,
  output logic                            wrap_o,
  output logic                            state_o
);

  localparam int MSG_W = DIGIT_W * DIGITS;
  localparam int POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DIGITS - 1);

  state_t            state_r;
  logic [MSG_W-1:0]  data_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [POS_W-1:0]  pos_r;

  logic              load_fire;
  logic              step;
  logic              rot_right;
  logic [POS_W-1:0]  pos_nxt;
  logic [MSG_W-1:0]  data_rot;

  assign load_fire = load_valid_i & (state_r == PAUSE);

  banner_step_timer #(
    .CNT_W (CNT_W)
  ) u_step_timer (
    .cnt    (cnt_r),
    .enable (state_r == RUN),
    .period (step_period_i),
    .clear  (load_fire),
    .step   (step)
  );

  always_comb begin
    pos_nxt  = pos_r;
    data_rot = data_r;
    if (rot_right) begin
      pos_nxt  = (pos_r == POS_LAST) ? '0 : pos_r + POS_W'(1);
      data_rot = MSG_W'(rotate_r(MSG_MAX_W'(data_r), MSG_W));
    end else begin
      pos_nxt  = (pos_r == '0) ? POS_LAST : pos_r - POS_W'(1);
      data_rot = MSG_W'(rotate_l(MSG_MAX_W'(data_r), MSG_W));
    end
  end

`ifdef BANNER_BOUNCE_EN
  localparam logic [POS_W-1:0] POS_TURN = POS_W'(DIGITS - WIN_DIGITS);

  logic dir_r;
  logic unused_dir;

  assign unused_dir = dir_i;
  assign rot_right  = dir_r;

  // Turn around once the window touches either end of the message.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_r <= 1'b1;
    end else if (load_fire) begin
      dir_r <= 1'b1;
    end else if (step) begin
      if (dir_r && (pos_nxt == POS_TURN))
        dir_r <= 1'b0;
      else if (!dir_r && (pos_nxt == '0))
        dir_r <= 1'b1;
    end
  end
`else
  assign rot_right = dir_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= PAUSE;
      data_r  <= RESET_MSG;
      cnt_r   <= '0;
      pos_r   <= '0;
    end else begin
      state_r <= run_i ? RUN : PAUSE;
      if (load_fire) begin
        data_r <= load_data_i;
        cnt_r  <= '0;
        pos_r  <= '0;
      end else if (state_r == RUN) begin
        if (step) begin
          data_r <= data_rot;
          cnt_r  <= '0;
          pos_r  <= pos_nxt;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign load_ready_o = (state_r == PAUSE);
  assign state_o      = (state_r == RUN);
  assign win_o        = data_r[DIGIT_W*WIN_DIGITS-1:0];
  assign step_o       = step;
  assign wrap_o       = step & (pos_nxt == '0);

endmodule

// File: tb/tb_banner_scroll_controller.sv
// Scoreboard bench for banner_scroll_controller against a digit-level reference model.
module tb_banner_scroll_controller;

  localparam int DIGITS = 10;
  localparam int WIN    = 4;
  localparam int CNT_W  = 27;
  localparam logic [39:0] RST_MSG = 40'h0123456789;

  typedef struct packed {
    logic [15:0] win;
    logic        step;
    logic        wrap;
    logic        ready;
    logic        state;
  } obs_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             run_i = 1'b0;
  logic             dir_i = 1'b1;
  logic [CNT_W-1:0] step_period_i = '0;
  logic             load_valid_i = 1'b0;
  logic [39:0]      load_data_i = '0;
  logic             load_ready_o;
  logic [15:0]      win_o;
  logic             step_o;
  logic             wrap_o;
  logic             state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_steps = 0;
  int n_wraps = 0;

  obs_t exp_q[$];

  // Reference model: original digits plus a window offset.
  logic [3:0] m_base[DIGITS];
  int         m_pos;
  int         m_cnt;
  logic       m_run;
  logic       m_bdir;

  banner_scroll_controller #(
    .DIGITS     (DIGITS),
    .WIN_DIGITS (WIN),
    .CNT_W      (CNT_W),
    .RESET_MSG  (RST_MSG)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .run_i         (run_i),
    .dir_i         (dir_i),
    .step_period_i (step_period_i),
    .load_valid_i  (load_valid_i),
    .load_data_i   (load_data_i),
    .load_ready_o  (load_ready_o),
    .win_o         (win_o),
    .step_o        (step_o),
    .wrap_o        (wrap_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t actual();
    obs_t a;
    a.win   = win_o;
    a.step  = step_o;
    a.wrap  = wrap_o;
    a.ready = load_ready_o;
    a.state = state_o;
    return a;
  endfunction

  task automatic model_set_msg(input logic [39:0] msg);
    logic [39:0] m;
    m = msg;
    for (int k = 0; k < DIGITS; k++) m_base[k] = m[4*k +: 4];
    m_pos  = 0;
    m_cnt  = 0;
    m_bdir = 1'b1;
  endtask

  task automatic model_reset();
    model_set_msg(RST_MSG);
    m_run = 1'b0;
  endtask

  // One clock cycle: drive, predict this cycle's outputs, advance the model.
  task automatic tick(input logic run, input logic dir, input int per,
                      input logic lv, input logic [39:0] ld);
    obs_t e;
    int   lim;
    logic right;
    logic stp;
    int   np;
    run_i         = run;
    dir_i         = dir;
    step_period_i = CNT_W'(per);
    load_valid_i  = lv;
    load_data_i   = ld;
    lim   = (per == 0) ? 1 : per;
`ifdef BANNER_BOUNCE_EN
    right = m_bdir;
`else
    right = dir;
`endif
    stp = m_run && (m_cnt >= lim - 1);
    np  = right ? (m_pos + 1) % DIGITS : (m_pos + DIGITS - 1) % DIGITS;
    for (int k = 0; k < WIN; k++) e.win[4*k +: 4] = m_base[(m_pos + k) % DIGITS];
    e.step  = stp;
    e.wrap  = stp && (np == 0);
    e.ready = !m_run;
    e.state = m_run;
    exp_q.push_back(e);
    if (stp) n_steps++;
    if (e.wrap) n_wraps++;
    if (lv && !m_run) begin
      model_set_msg(ld);
    end else if (m_run) begin
      if (stp) begin
        m_pos = np;
        m_cnt = 0;
`ifdef BANNER_BOUNCE_EN
        if (m_bdir && np == DIGITS - WIN) m_bdir = 1'b0;
        else if (!m_bdir && np == 0) m_bdir = 1'b1;
`endif
      end else begin
        m_cnt++;
      end
    end
    m_run = run;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: compare every observed cycle against the queued prediction.
  always @(negedge clk_i) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = actual();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got win=%h step=%b wrap=%b ready=%b state=%b expected win=%h step=%b wrap=%b ready=%b state=%b",
                 $time, a.win, a.step, a.wrap, a.ready, a.state,
                 e.win, e.step, e.wrap, e.ready, e.state);
      end
    end
  end

  task automatic check_direct(input string name, input obs_t e);
    obs_t a;
    a = actual();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, a, e);
    end
  endtask

  initial begin
    logic [63:0] rnd;
    int          guard;
    int          s0;
    int          w0;

    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state, then scroll right with period 3.
    tick(1'b0, 1'b1, 3, 1'b0, '0);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 3, 1'b0, '0);

    // Ten-plus right steps at period 1 to cross the wrap.
    for (int i = 0; i < 25; i++) tick(1'b1, 1'b1, 1, 1'b0, '0);
    // Left scrolling.
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, 2, 1'b0, '0);

    // Pause mid-count, hold, resume.
    guard = 0;
    while (m_cnt != 1 && guard < 20) begin
      tick(1'b1, 1'b1, 3, 1'b0, '0);
      guard++;
    end
    n_tests++;
    if (m_cnt != 1) begin
      n_fail++;
      $display("FAIL pause_setup got cnt=%0d expected 1", m_cnt);
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 3, 1'b0, '0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 3, 1'b0, '0);

    // Load attempt while running is ignored; load in pause takes effect.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 3, 1'b1, 40'hFEDCBA9876);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 3, 1'b0, '0);
    tick(1'b0, 1'b1, 3, 1'b1, 40'hAAAABBBBCC);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 3, 1'b0, '0);
    // Load coinciding with run rising.
    tick(1'b1, 1'b1, 4, 1'b1, 40'h13579BDF02);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 4, 1'b0, '0);

    // Period zero steps every cycle.
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 0, 1'b0, '0);

    // Shortened period fires immediately.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8, 1'b0, '0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 2, 1'b0, '0);

    // Randomized traffic.
    s0 = n_steps;
    w0 = n_wraps;
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom(), $urandom()};
      tick(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0), rnd[39:0]);
    end
    n_tests++;
    if (n_steps - s0 == 0) begin
      n_fail++;
      $display("FAIL random_activity got steps=%0d wraps=%0d expected nonzero steps",
               n_steps - s0, n_wraps - w0);
    end

    // Asynchronous reset in the middle of a cycle while running.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1, 1'b0, '0);
    #2;
    rst_i = 1'b1;
    #1;
    check_direct("async_reset", '{win: 16'h6789, step: 1'b0, wrap: 1'b0,
                                  ready: 1'b1, state: 1'b0});
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 2, 1'b0, '0);

    @(negedge clk_i);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
